// File: rtl/cla_8bit.sv
// 8-bit two-level carry-lookahead adder with one registered output stage.
// Two 4-bit lookahead groups feed a group-level carry unit; the result is
// captured when in_valid is high and held otherwise.
// Optional: define CLA_8BIT_OVF_EN to add a registered signed-overflow output.
module cla_8bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout,
  output logic       out_valid
`ifdef CLA_8BIT_OVF_EN
  ,
  output logic       ovf
`endif
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;
  logic [1:0] grp_g;
  logic [1:0] grp_p;
  logic [7:0] sum;

  // Bit generate/propagate, group G/P, and fully expanded lookahead carries
  always_comb begin
    g = a & b;
    p = a ^ b;

    grp_p[0] = &p[3:0];
    grp_g[0] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
    grp_p[1] = &p[7:4];
    grp_g[1] = g[7] | (p[7] & g[6]) | (p[7] & p[6] & g[5])
             | (p[7] & p[6] & p[5] & g[4]);

    // Group-level carry unit
    c[0] = cin;
    c[4] = grp_g[0] | (grp_p[0] & cin);
    c[8] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);

    // Lower group internal carries, expanded from c[0]
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);

    // Upper group internal carries, expanded from c[4]
    c[5] = g[4] | (p[4] & c[4]);
    c[6] = g[5] | (p[5] & g[4]) | (p[5] & p[4] & c[4]);
    c[7] = g[6] | (p[6] & g[5]) | (p[6] & p[5] & g[4])
         | (p[6] & p[5] & p[4] & c[4]);

    sum = p ^ c[7:0];
  end

  // Result register: capture on in_valid, hold otherwise; valid tracks in_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s         <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s    <= sum;
        cout <= c[8];
      end
    end
  end

`ifdef CLA_8BIT_OVF_EN
  // Signed overflow flag registered alongside the sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= c[8] ^ c[7];
    end
  end
`endif

endmodule

// File: tb/tb_cla_8bit.sv
// Directed and random bench for cla_8bit using an expected-result queue.
module tb_cla_8bit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic [7:0] s;
  logic       cout;
  logic       out_valid;
`ifdef CLA_8BIT_OVF_EN
  logic       ovf;
`endif

  int unsigned total = 0;
  int unsigned passed = 0;

  // {ovf, cout, s}
  logic [9:0] sb_q[$];
  logic [9:0] last_exp = '0;

  cla_8bit dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .a(a),
    .b(b),
    .cin(cin),
    .s(s),
    .cout(cout),
    .out_valid(out_valid)
`ifdef CLA_8BIT_OVF_EN
    ,
    .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                       input logic mc);
    int unsigned u;
    int sa;
    int sb2;
    int t;
    logic o;
    u   = int'(ma) + int'(mb) + int'(mc);
    sa  = $signed(ma);
    sb2 = $signed(mb);
    t   = sa + sb2 + int'(mc);
    o   = (t > 127) || (t < -128);
    return {o, u[8:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Compare all outputs against the held/popped expectation
  task automatic chk_outputs(input string tag, input logic [9:0] e);
    chk({tag, ".s"}, 32'(s), 32'(e[7:0]));
    chk({tag, ".cout"}, 32'(cout), 32'(e[8]));
`ifdef CLA_8BIT_OVF_EN
    chk({tag, ".ovf"}, 32'(ovf), 32'(e[9]));
`endif
  endtask

  // Drive one cycle of stimulus, then check what the DUT registered on that edge
  task automatic step(input string tag, input logic v, input logic [7:0] ta,
                      input logic [7:0] tb_, input logic tc);
    in_valid = v;
    a        = ta;
    b        = tb_;
    cin      = tc;
    if (v) sb_q.push_back(model(ta, tb_, tc));
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    if (out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk({tag, ".queue_nonempty"}, 32'd0, 32'd1);
      end else begin
        last_exp = sb_q.pop_front();
        chk_outputs(tag, last_exp);
      end
    end else begin
      chk_outputs({tag, ".hold"}, last_exp);
    end
  endtask

  initial begin
    // Reset state
    #2;
    chk("reset.s", 32'(s), 32'h0);
    chk("reset.cout", 32'(cout), 32'h0);
    chk("reset.out_valid", 32'(out_valid), 32'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    step("carry_chain", 1'b1, 8'hFF, 8'h00, 1'b1);
    step("max", 1'b1, 8'hFF, 8'hFF, 1'b1);
    step("grp_boundary", 1'b1, 8'h0F, 8'h01, 1'b0);
    step("hold_load", 1'b1, 8'h12, 8'h34, 1'b0);
    step("hold_idle", 1'b0, 8'hAA, 8'h34, 1'b0);
    chk("hold.s_value", 32'(s), 32'h46);
    step("hold_idle2", 1'b0, 8'h55, 8'h99, 1'b1);
    step("ovf_pos", 1'b1, 8'h7F, 8'h01, 1'b0);
    step("ovf_neg", 1'b1, 8'h80, 8'hFF, 1'b0);
    step("zero", 1'b1, 8'h00, 8'h00, 1'b0);

    // Asynchronous reset mid-cycle after a nonzero result, with one in flight
    step("pre_reset", 1'b1, 8'h21, 8'h43, 1'b1);
    in_valid = 1'b1;
    a = 8'h99;
    b = 8'h11;
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst.s", 32'(s), 32'h0);
    chk("async_rst.cout", 32'(cout), 32'h0);
    chk("async_rst.out_valid", 32'(out_valid), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_held.s", 32'(s), 32'h0);
    chk("rst_held.out_valid", 32'(out_valid), 32'h0);
    sb_q.delete();
    last_exp = '0;
    in_valid = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("post_rst_idle", 1'b0, 8'hFE, 8'h01, 1'b1);

    // Random back-to-back regression
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'b1, 8'($urandom_range(255)), 8'($urandom_range(255)),
           1'($urandom_range(1)));
    end
    step("drain", 1'b0, 8'h00, 8'h00, 1'b0);
    chk("queue_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
